// File: rtl/udc_bus_master.sv
// Host-side initiator for the up/down counter register bus (ncs/nwr/nrd/A1:A0/data) plus start pulse.
// Optional macro UDC_BM_STATS_EN adds saturating completed-write/read counters (wr_cnt_o, rd_cnt_o).
module udc_bus_master #(
  parameter int DW     = 8,
  parameter int SETUP  = 1,
  parameter int STROBE = 2,
  parameter int HOLD   = 1
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_wr_i,
  input  logic [1:0]    req_addr_i,
  input  logic [DW-1:0] req_wdata_i,
  output logic          rsp_valid_o,
  output logic [DW-1:0] rsp_rdata_o,
  input  logic          start_req_i,
  output logic          ncs_o,
  output logic          nwr_o,
  output logic          nrd_o,
  output logic          a0_o,
  output logic          a1_o,
  output logic [DW-1:0] d_o,
  output logic          d_oe_o,
  input  logic [DW-1:0] d_i,
  output logic          busy_o,
`ifdef UDC_BM_STATS_EN
  output logic [15:0]   wr_cnt_o,
  output logic [15:0]   rd_cnt_o,
`endif
  output logic          start_o
);

  // state     | meaning
  // ST_IDLE   | bus released, ncs high; accepts requests or fires a pending start
  // ST_SETUP  | ncs low, address (and write data) driven ahead of the strobe
  // ST_STROBE | nwr or nrd low; read data captured on the last cycle's edge
  // ST_HOLD   | strobe released, ncs/address/data still held
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  localparam logic [7:0] SETUP_LD  = 8'(SETUP - 1);
  localparam logic [7:0] STROBE_LD = 8'(STROBE - 1);
  localparam logic [7:0] HOLD_LD   = 8'(HOLD - 1);

  logic [1:0]    state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [1:0]    addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          start_pend_q, start_pend_d;

  logic idle, last, start_fire, accept;

  assign idle       = (state_q == ST_IDLE);
  assign last       = (cnt_q == 8'd0);
  assign start_fire = idle & start_pend_q;
  assign accept     = req_valid_i & req_ready_o;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    // a request arriving on the firing cycle re-arms the flag; earlier ones merge
    start_pend_d = start_req_i | (start_pend_q & ~start_fire);
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          wr_d    = req_wr_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          rdata_d = '0;
          cnt_d   = SETUP_LD;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (last) begin
          cnt_d   = STROBE_LD;
          state_d = ST_STROBE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_STROBE: begin
        if (last) begin
          if (!wr_q) rdata_d = d_i;
          cnt_d   = HOLD_LD;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_HOLD: begin
        if (last) begin
          rsp_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      wr_q         <= 1'b0;
      addr_q       <= 2'b00;
      wdata_q      <= '0;
      rdata_q      <= '0;
      rsp_valid_q  <= 1'b0;
      start_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      rsp_valid_q  <= rsp_valid_d;
      start_pend_q <= start_pend_d;
    end
  end

  // every bus pin decodes from registered state only
  assign req_ready_o = idle & ~start_pend_q;
  assign start_o     = start_fire;
  assign busy_o      = ~idle;
  assign ncs_o       = idle;
  assign nwr_o       = ~((state_q == ST_STROBE) & wr_q);
  assign nrd_o       = ~((state_q == ST_STROBE) & ~wr_q);
  assign a0_o        = addr_q[0];
  assign a1_o        = addr_q[1];
  assign d_o         = wdata_q;
  assign d_oe_o      = ~idle & wr_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_valid_q ? rdata_q : '0;

`ifdef UDC_BM_STATS_EN
  logic [15:0] wr_cnt_q, rd_cnt_q;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_cnt_q <= 16'd0;
      rd_cnt_q <= 16'd0;
    end else if (rsp_valid_d) begin
      if (wr_q && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      if (!wr_q && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
    end
  end

  assign wr_cnt_o = wr_cnt_q;
  assign rd_cnt_o = rd_cnt_q;
`endif

endmodule

// File: tb/tb_udc_bus_master.sv
// Directed bench for udc_bus_master at default timing (SETUP=1, STROBE=2, HOLD=1).
// Covers the stats counters when UDC_BM_STATS_EN is defined.
module tb_udc_bus_master;

  logic       clk;
  logic       rst_n;
  logic       req_valid_i, req_ready_o, req_wr_i;
  logic [1:0] req_addr_i;
  logic [7:0] req_wdata_i;
  logic       rsp_valid_o;
  logic [7:0] rsp_rdata_o;
  logic       start_req_i, start_o;
  logic       ncs_o, nwr_o, nrd_o, a0_o, a1_o, d_oe_o, busy_o;
  logic [7:0] d_o, d_i;
`ifdef UDC_BM_STATS_EN
  logic [15:0] wr_cnt_o, rd_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  udc_bus_master dut (
    .clock_i     (clk),
    .reset_i     (rst_n),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_wr_i    (req_wr_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .start_req_i (start_req_i),
    .ncs_o       (ncs_o),
    .nwr_o       (nwr_o),
    .nrd_o       (nrd_o),
    .a0_o        (a0_o),
    .a1_o        (a1_o),
    .d_o         (d_o),
    .d_oe_o      (d_oe_o),
    .d_i         (d_i),
    .busy_o      (busy_o),
`ifdef UDC_BM_STATS_EN
    .wr_cnt_o    (wr_cnt_o),
    .rd_cnt_o    (rd_cnt_o),
`endif
    .start_o     (start_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       wr;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] din;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // bus word: {ncs, nwr, nrd, d_oe, busy, rsp_valid, req_ready, start}
  function automatic logic [7:0] bus_word();
    return {ncs_o, nwr_o, nrd_o, d_oe_o, busy_o, rsp_valid_o, req_ready_o, start_o};
  endfunction

  // k = cycles after accept: 1 setup, 2-3 strobe, 4 hold, 5 idle with response
  task automatic check_cycle(input string tag, input int k, input logic wr,
                             input logic [1:0] addr, input logic [7:0] wdata,
                             input logic [7:0] exp_rdata, input logic start5);
    logic active, strobe;
    logic [7:0] exp;
    active = (k <= 4);
    strobe = (k == 2) || (k == 3);
    exp = {~active, ~(strobe & wr), ~(strobe & ~wr), active & wr, active,
           (k == 5), (k == 5) & ~start5, (k == 5) & start5};
    chk($sformatf("%s bus c%0d", tag, k), {8'h00, bus_word()}, {8'h00, exp});
    chk($sformatf("%s addr c%0d", tag, k), {14'd0, a1_o, a0_o}, {14'd0, addr});
    if (wr) chk($sformatf("%s d_o c%0d", tag, k), {8'h00, d_o}, {8'h00, wdata});
    if (k == 5) chk($sformatf("%s rdata", tag), {8'h00, rsp_rdata_o}, {8'h00, exp_rdata});
  endtask

  task automatic present(input logic wr, input logic [1:0] addr, input logic [7:0] wdata);
    req_valid_i = 1'b1;
    req_wr_i    = wr;
    req_addr_i  = addr;
    req_wdata_i = wdata;
  endtask

  initial begin
    vec_t v;
    int exp_wr, exp_rd;
    vecs[0] = '{wr: 1'b1, addr: 2'b01, wdata: 8'hA5, din: 8'h00, exp_rdata: 8'h00};
    vecs[1] = '{wr: 1'b0, addr: 2'b10, wdata: 8'h5A, din: 8'h3C, exp_rdata: 8'h3C};
    vecs[2] = '{wr: 1'b1, addr: 2'b11, wdata: 8'hFF, din: 8'h81, exp_rdata: 8'h00};
    vecs[3] = '{wr: 1'b0, addr: 2'b00, wdata: 8'h00, din: 8'hC3, exp_rdata: 8'hC3};
    vecs[4] = '{wr: 1'b1, addr: 2'b00, wdata: 8'h12, din: 8'h77, exp_rdata: 8'h00};
    exp_wr = 0;
    exp_rd = 0;

    rst_n = 1'b0;
    req_valid_i = 1'b0; req_wr_i = 1'b0; req_addr_i = 2'b00; req_wdata_i = 8'h00;
    start_req_i = 1'b0; d_i = 8'h00;
    #3;
    chk("reset bus", {8'h00, bus_word()}, 16'h00E2);
    chk("reset addr", {14'd0, a1_o, a0_o}, 16'h0000);
    chk("reset d_o", {8'h00, d_o}, 16'h0000);
    chk("reset rdata", {8'h00, rsp_rdata_o}, 16'h0000);
`ifdef UDC_BM_STATS_EN
    chk("reset wr_cnt", wr_cnt_o, 16'd0);
    chk("reset rd_cnt", rd_cnt_o, 16'd0);
`endif
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // table: single transactions; d_i carries the true value only in the last strobe cycle
    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      present(v.wr, v.addr, v.wdata);
      d_i = ~v.din;
      chk($sformatf("v%0d ready", i), {15'd0, req_ready_o}, 16'd1);
      tick();
      req_valid_i = 1'b0;
      for (int k = 1; k <= 5; k++) begin
        d_i = (k == 3) ? v.din : ~v.din;
        check_cycle($sformatf("v%0d", i), k, v.wr, v.addr, v.wdata, v.exp_rdata, 1'b0);
        tick();
      end
      if (v.wr) exp_wr++; else exp_rd++;
    end
`ifdef UDC_BM_STATS_EN
    chk("stats wr_cnt", wr_cnt_o, 16'(exp_wr));
    chk("stats rd_cnt", rd_cnt_o, 16'(exp_rd));
`endif

    // back-to-back: valid held, second accepted in the response cycle
    present(1'b1, 2'b10, 8'h11);
    tick();
    present(1'b1, 2'b11, 8'h22);
    for (int k = 1; k <= 5; k++) begin
      check_cycle("b2b_a", k, 1'b1, 2'b10, 8'h11, 8'h00, 1'b0);
      tick();
    end
    req_valid_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      check_cycle("b2b_b", k, 1'b1, 2'b11, 8'h22, 8'h00, 1'b0);
      tick();
    end

    // start requests merge and pre-empt a waiting request
    present(1'b1, 2'b01, 8'h44);
    tick();
    req_valid_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      start_req_i = (k == 2) || (k == 4);
      if (k == 4) present(1'b0, 2'b10, 8'h00);
      check_cycle("st_a", k, 1'b1, 2'b01, 8'h44, 8'h00, 1'b1);
      tick();
      start_req_i = 1'b0;
    end
    chk("st idle", {8'h00, bus_word()}, 16'h00E2);
    d_i = 8'h96;
    tick();
    req_valid_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      d_i = (k == 3) ? 8'h69 : 8'h96;
      check_cycle("st_b", k, 1'b0, 2'b10, 8'h00, 8'h69, 1'b0);
      tick();
    end

    // start requested while idle
    start_req_i = 1'b1;
    tick();
    start_req_i = 1'b0;
    chk("idle start", {8'h00, bus_word()}, 16'h00E1);
    tick();
    chk("idle start done", {8'h00, bus_word()}, 16'h00E2);

    // reset mid-strobe with a pending start
    present(1'b1, 2'b11, 8'h99);
    tick();
    req_valid_i = 1'b0;
    start_req_i = 1'b1;
    check_cycle("rst", 1, 1'b1, 2'b11, 8'h99, 8'h00, 1'b0);
    tick();
    start_req_i = 1'b0;
    chk("rst pre nwr", {15'd0, nwr_o}, 16'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst bus", {8'h00, bus_word()}, 16'h00E2);
    chk("rst addr", {14'd0, a1_o, a0_o}, 16'h0000);
    chk("rst d_o", {8'h00, d_o}, 16'h0000);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("post rst c%0d", k), {8'h00, bus_word()}, 16'h00E2);
    end
`ifdef UDC_BM_STATS_EN
    chk("post rst wr_cnt", wr_cnt_o, 16'd0);
    chk("post rst rd_cnt", rd_cnt_o, 16'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
